systolic_feeder: RTL and testbench

- Drives the left and top edges of an N×N output-stationary bfloat16 systolic array of `pe` cells.
- Holds one N×N A operand and one N×N B operand in internal register buffers, loaded through a simple write port.
- On `start`, it clears the array accumulators, then streams A rows and B columns with the diagonal skew the array needs.
- Reports completion once every PE has accumulated all N products.

---
 rtl/systolic_feeder.sv | 107 ++++++++++
 tb/tb_systolic_feeder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand buffer and skewed edge driver for an N x N output-stationary bfloat16 systolic array.
// Clears the array, then streams A rows and B columns with a per-lane diagonal delay.
module systolic_feeder #(
    parameter int BW = 16,
    parameter int N  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [$clog2(N)-1:0] wr_col,
    input  logic [BW-1:0]        wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 arr_clr_n,
    output logic [N*BW-1:0]      row_data,
    output logic [N*BW-1:0]      col_data
);
    localparam int IW    = $clog2(N);
    localparam int KW    = $clog2(3 * N);
    localparam int KLAST = 3 * N - 3;

    typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

    state_t          state_reg, state_next;
    logic [KW-1:0]   k_reg, k_next;
    logic [BW-1:0]   a_mem [N][N];
    logic [BW-1:0]   b_mem [N][N];
    logic [N*BW-1:0] row_next, col_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                    k_next     = '0;
                end
            end
            CLEAR: begin
                state_next = FEED;
                k_next     = '0;
            end
            FEED: begin
                if (k_reg == KW'(KLAST)) state_next = DONE;
                else                     k_next     = k_reg + 1'b1;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Writes are only honoured while idle so a running product never sees a torn operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (state_reg == IDLE && wr_en) begin
            if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
            else        a_mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Lane gi lags by gi steps; an out-of-window index (including negative wrap) feeds +0.0.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam logic [KW:0] OFF = (KW+1)'(gi);
        logic [KW:0] diff;
        logic        in_win;
        assign diff   = {1'b0, k_next} - OFF;
        assign in_win = (state_next == FEED) && (diff < (KW+1)'(N));
        assign row_next[gi*BW +: BW] = in_win ? a_mem[gi][diff[IW-1:0]] : '0;
        assign col_next[gi*BW +: BW] = in_win ? b_mem[diff[IW-1:0]][gi] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            arr_clr_n <= 1'b1;
            row_data  <= '0;
            col_data  <= '0;
        end else begin
            busy      <= (state_next == CLEAR) || (state_next == FEED);
            done      <= (state_next == DONE);
            arr_clr_n <= (state_next != CLEAR);
            row_data  <= row_next;
            col_data  <= col_next;
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4): reset, skew pattern, ignored inputs,
// mid-run reset, write-with-start and an identity operand run.
module tb_systolic_feeder;
    localparam int BW = 16;
    localparam int N  = 4;
    localparam int KL = 3 * N - 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [1:0]    wr_row = '0;
    logic [1:0]    wr_col = '0;
    logic [BW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          busy, done, arr_clr_n;
    logic [N*BW-1:0] row_data, col_data;

    int tests = 0;
    int fails = 0;

    logic [BW-1:0]   a_m [N][N];
    logic [BW-1:0]   b_m [N][N];
    logic [N*BW-1:0] row_cap [KL];
    logic [N*BW-1:0] col_cap [KL];

    systolic_feeder #(.BW(BW), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
        .busy(busy), .done(done), .arr_clr_n(arr_clr_n),
        .row_data(row_data), .col_data(col_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int r, input int c, input logic [BW-1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic load_all();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, a_m[r][c]);
                wr(1'b1, r, c, b_m[r][c]);
            end
    endtask

    task automatic set_pattern();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a_m[r][c] = 16'h1000 + 16'(16 * r + c);
                b_m[r][c] = 16'h2000 + 16'(16 * r + c);
            end
    endtask

    function automatic logic [N*BW-1:0] exp_row(input int k);
        logic [N*BW-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (k - i >= 0 && k - i < N) v[i*BW +: BW] = a_m[i][k-i];
        return v;
    endfunction

    function automatic logic [N*BW-1:0] exp_col(input int k);
        logic [N*BW-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (k - j >= 0 && k - j < N) v[j*BW +: BW] = b_m[k-j][j];
        return v;
    endfunction

    // Starts a run (any pending write fields stay applied in the start cycle) and checks every cycle.
    task automatic run_check(input string tag);
        start = 1'b1;
        step();
        start = 1'b0; wr_en = 1'b0;
        chk({tag, "_clr_n"}, 64'(arr_clr_n), 64'd0);
        chk({tag, "_clr_busy"}, 64'(busy), 64'd1);
        chk({tag, "_clr_rows"}, 64'(row_data), 64'd0);
        for (int k = 0; k < KL; k++) begin
            step();
            row_cap[k] = row_data;
            col_cap[k] = col_data;
            chk($sformatf("%s_row_k%0d", tag, k), 64'(row_data), 64'(exp_row(k)));
            chk($sformatf("%s_col_k%0d", tag, k), 64'(col_data), 64'(exp_col(k)));
            chk($sformatf("%s_ctl_k%0d", tag, k), {61'd0, busy, arr_clr_n, done}, 64'b110);
        end
        step();
        chk({tag, "_done"}, {62'd0, busy, done}, 64'b01);
        chk({tag, "_done_lanes"}, 64'(row_data | col_data), 64'd0);
        step();
        chk({tag, "_idle"}, {62'd0, busy, done}, 64'b00);
        $display("[TB] run %s complete", tag);
    endtask

    initial begin
        int ndone, dcyc;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_held", {busy, done, arr_clr_n, row_data, col_data} != '0 ? 64'(arr_clr_n & ~busy & ~done) : 64'd0, 64'd1);
        rst_n = 1'b1;
        step(); step();
        chk("rst_ctl", {61'd0, busy, done, arr_clr_n}, 64'b001);
        chk("rst_row", 64'(row_data), 64'd0);
        chk("rst_col", 64'(col_data), 64'd0);
        $display("[TB] reset checks done");

        // Skew pattern
        set_pattern();
        load_all();
        run_check("skew");
        chk("k3_row", 64'(row_cap[3]), 64'h1030_1021_1012_1003);
        chk("k3_col", 64'(col_cap[3]), 64'h2003_2012_2021_2030);
        chk("k0_row", 64'(row_cap[0]), 64'h0000_0000_0000_1000);
        chk("k0_col", 64'(col_cap[0]), 64'h0000_0000_0000_2000);
        chk("k7_9_zero", 64'(row_cap[7] | row_cap[8] | row_cap[9] | col_cap[7] | col_cap[8] | col_cap[9]), 64'd0);

        // Writes and start during FEED are ignored
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0; dcyc = -1;
        for (int c = 1; c <= 15; c++) begin
            if (c == 3) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 16'h4000;
                start = 1'b1;
            end
            step();
            wr_en = 1'b0; start = 1'b0;
            if (done) begin ndone++; dcyc = c; end
        end
        chk("busy_one_done", 64'(ndone), 64'd1);
        chk("busy_done_cycle", 64'(dcyc), 64'd11);
        run_check("after_busy");
        chk("old_a00", 64'(row_cap[0][15:0]), 64'h1000);

        // Reset mid-run at FEED k=5
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("pre_rst_k5", 64'(row_data), 64'(exp_row(5)));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctl", {61'd0, busy, done, arr_clr_n}, 64'b001);
        chk("midrst_lanes", 64'(row_data | col_data), 64'd0);
        step(); step();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (done || busy) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);
        load_all();
        run_check("reload");

        // Write coincident with start is used by the run
        a_m[3][3] = 16'h4040;
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd3; wr_col = 2'd3; wr_data = 16'h4040;
        run_check("wr_start");
        chk("wr_start_k6", 64'(row_cap[6][3*BW +: BW]), 64'h4040);

        // Identity A, B[m][j] = bf16(m+j+1)
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                logic [BW-1:0] bf [8];
                bf = '{16'h0000, 16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0};
                a_m[r][c] = (r == c) ? 16'h3F80 : 16'h0000;
                b_m[r][c] = bf[r + c + 1];
            end
        load_all();
        run_check("ident");
        chk("ident_k6_col3", 64'(col_cap[6][3*BW +: BW]), 64'h40E0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
